clk_div_prog: RTL

- Runtime-programmable integer clock divider; next generation of the fixed divide-by-16 block.
- Generates a registered divided clock `clk_out` plus a one-cycle `tick` strobe per output period.
- Provides glitch-free start/stop and a valid/ready divisor-update port applied only at period boundaries.
- Sits between the system clock and slow peripherals (LED scan, UART baud, sample strobes).

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_cfg_hold.sv | 85 ++++++++
 rtl/clk_div_prog.sv | 106 ++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Optional duty-cycle control is enabled by defining CLK_DIV_DUTY_EN.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // High time must leave at least one low cycle in a period of n.
  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned n);
    if (duty < 1) return 1;
    if (duty > n - 1) return n - 1;
    return duty;
  endfunction

endpackage

// File: rtl/clk_div_cfg_hold.sv
// Divisor staging: one-deep pending register behind a valid/ready port,
// committed to the active divisor when apply_i is high. CLK_DIV_DUTY_EN adds duty.
module clk_div_cfg_hold
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apply_i,
  input  logic             div_valid_i,
  input  logic [CNT_W-1:0] div_i,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_i,
  output logic [CNT_W-1:0] cur_duty_o,
`endif
  output logic             div_ready_o,
  output logic [CNT_W-1:0] cur_div_o
);

  logic             pend_full_q, pend_full_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             xfer;
`ifdef CLK_DIV_DUTY_EN
  logic [CNT_W-1:0] pend_duty_q, pend_duty_d;
  logic [CNT_W-1:0] cur_duty_q, cur_duty_d;
`endif

  assign xfer        = div_valid_i && !pend_full_q;
  assign div_ready_o = !pend_full_q;
  assign cur_div_o   = cur_div_q;

  // A transfer only happens into an empty slot, so it can never be consumed
  // by an apply on the same edge; it waits for the next strobe.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_div_d  = pend_div_q;
    cur_div_d   = cur_div_q;
`ifdef CLK_DIV_DUTY_EN
    pend_duty_d = pend_duty_q;
    cur_duty_d  = cur_duty_q;
`endif
    if (apply_i && pend_full_q) begin
      cur_div_d   = pend_div_q;
`ifdef CLK_DIV_DUTY_EN
      cur_duty_d  = pend_duty_q;
`endif
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_div_d  = CNT_W'(clamp_div(32'(div_i)));
`ifdef CLK_DIV_DUTY_EN
      pend_duty_d = CNT_W'(clamp_duty(32'(duty_i), clamp_div(32'(div_i))));
`endif
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_div_q  <= '0;
      cur_div_q   <= CNT_W'(DEFAULT_DIV);
`ifdef CLK_DIV_DUTY_EN
      pend_duty_q <= '0;
      cur_duty_q  <= CNT_W'(DEFAULT_DIV / 2);
`endif
    end else begin
      pend_full_q <= pend_full_d;
      pend_div_q  <= pend_div_d;
      cur_div_q   <= cur_div_d;
`ifdef CLK_DIV_DUTY_EN
      pend_duty_q <= pend_duty_d;
      cur_duty_q  <= cur_duty_d;
`endif
    end
  end

`ifdef CLK_DIV_DUTY_EN
  assign cur_duty_o = cur_duty_q;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free start/stop.
// Define CLK_DIV_DUTY_EN to add programmable high time (duty_in/cur_duty).
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [CNT_W-1:0] cur_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_in,
  output logic [CNT_W-1:0] cur_duty,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx, h;
  logic             clk_out_q, clk_out_d;
  logic             last, apply;

  clk_div_cfg_hold #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_cfg (
    .clk        (clk),
    .rst_n      (rst_n),
    .apply_i    (apply),
    .div_valid_i(div_valid),
    .div_i      (div_in),
`ifdef CLK_DIV_DUTY_EN
    .duty_i     (duty_in),
    .cur_duty_o (cur_duty),
`endif
    .div_ready_o(div_ready),
    .cur_div_o  (cur_div)
  );

`ifdef CLK_DIV_DUTY_EN
  assign h = cur_duty;
`else
  assign h = cur_div - (cur_div >> 1);
`endif

  assign last    = (cnt_q == cur_div - CNT_W'(1));
  assign cnt_nx  = last ? '0 : cnt_q + CNT_W'(1);
  assign running = (state_q != IDLE);
  assign tick    = running && last;
  assign clk_out = clk_out_q;

  // At a wrap cnt_nx is 0 and h >= 1, so the first cycle of a period is high
  // no matter which divisor takes effect on that edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        apply     = 1'b1;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (en) begin
          state_d   = RUN;
          clk_out_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        apply     = last;
        cnt_d     = cnt_nx;
        clk_out_d = (cnt_nx < h);
        if (en) begin
          state_d = RUN;
        end else if (last) begin
          state_d   = IDLE;
          cnt_d     = '0;
          clk_out_d = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

endmodule
